touch_scan_sequencer: RTL and testbench

//  Fabric-side resistive touch-panel scan engine, parametrised successor of the fixed 2-channel ADC/GPIO hookup.

---
 rtl/touch_scan_sequencer.sv | 244 ++++++++++++++++++++++++
 tb/tb_touch_scan_sequencer.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/touch_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : touch_scan_sequencer
//  Desc     : Resistive touch-panel scan engine: drive, settle, convert,
//             average, publish. Optional gate macro: TOUCH_SCAN_GATE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module touch_scan_sequencer #(
    parameter int                       NUM_CH       = 2,
    parameter int                       ADC_W        = 12,
    parameter int                       AVG_LOG2     = 2,
    parameter int                       DRV_W        = 4,
    parameter logic [NUM_CH*DRV_W-1:0]  DRV_OE_PAT   = 8'hC3,
    parameter logic [NUM_CH*DRV_W-1:0]  DRV_VAL_PAT  = 8'h41,
    parameter int                       SETTLE_CYC   = 1000,
    parameter int                       ADC_TIMEOUT  = 4096,
    parameter logic [ADC_W-1:0]         TOUCH_THRESH = 12'd200,
    localparam int                      c_ch_w       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                        FAB_CLK,
    input  logic                        FAB_RESET,
    input  logic                        enable,
    output logic [DRV_W-1:0]            drive_oe,
    output logic [DRV_W-1:0]            drive_out,
    output logic                        adc_req,
    output logic [c_ch_w-1:0]           adc_ch,
    input  logic                        adc_valid,
    input  logic [ADC_W-1:0]            adc_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_CH*ADC_W-1:0]     out_data,
    output logic                        touch_active,
    output logic                        err_timeout
);

    localparam int c_nsamp = 1 << AVG_LOG2;
    localparam int c_acc_w = ADC_W + AVG_LOG2;
    localparam int c_cnt_w = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int c_set_w = $clog2(SETTLE_CYC + 1);
    localparam int c_tmo_w = $clog2(ADC_TIMEOUT + 1);
    localparam int c_res_w = NUM_CH * ADC_W;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DRIVE   = 3'd1,
        S_SETTLE  = 3'd2,
        S_CONVERT = 3'd3,
        S_ACCUM   = 3'd4,
        S_PUBLISH = 3'd5
    } state_t;

    state_t               r_state_q,    w_state_d;
    logic [c_ch_w-1:0]    r_ch_q,       w_ch_d;
    logic [c_set_w-1:0]   r_set_q,      w_set_d;
    logic [c_tmo_w-1:0]   r_tmo_q,      w_tmo_d;
    logic [c_cnt_w-1:0]   r_cnt_q,      w_cnt_d;
    logic [c_acc_w-1:0]   r_acc_q,      w_acc_d;
    logic [ADC_W-1:0]     r_smp_q,      w_smp_d;
    logic [c_res_w-1:0]   r_res_q,      w_res_d;
    logic [c_res_w-1:0]   r_out_data_q, w_out_data_d;
    logic                 r_out_valid_q, w_out_valid_d;
    logic                 r_adc_req_q,  w_adc_req_d;
    logic [DRV_W-1:0]     r_oe_q,       w_oe_d;
    logic [DRV_W-1:0]     r_val_q,      w_val_d;
    logic                 r_err_q,      w_err_d;

    logic [c_acc_w-1:0]   w_sum;
    logic [ADC_W-1:0]     w_avg;
    logic [c_res_w-1:0]   w_res_new;
    logic                 w_last_smp;
    logic                 w_last_ch;
    logic                 w_frame_keep;

    always_comb begin
        w_sum      = r_acc_q + c_acc_w'(r_smp_q);
        w_avg      = ADC_W'(w_sum >> AVG_LOG2);
        w_res_new  = r_res_q;
        w_res_new[int'(r_ch_q)*ADC_W +: ADC_W] = w_avg;
        w_last_smp = (r_cnt_q == c_cnt_w'(c_nsamp - 1));
        w_last_ch  = (r_ch_q == c_ch_w'(NUM_CH - 1));
    end

`ifdef TOUCH_SCAN_GATE_EN
    logic r_touch_q, w_touch_d;
    // Frames whose ch0 average sits below threshold are treated as no-touch and dropped.
    assign w_frame_keep = (w_res_new[ADC_W-1:0] >= TOUCH_THRESH);
    assign touch_active = r_touch_q;
`else
    logic w_unused_thresh;
    assign w_unused_thresh = ^TOUCH_THRESH;
    assign w_frame_keep    = 1'b1;
    assign touch_active    = 1'b1;
`endif

    always_comb begin
        w_state_d    = r_state_q;
        w_ch_d       = r_ch_q;
        w_set_d      = r_set_q;
        w_cnt_d      = r_cnt_q;
        w_acc_d      = r_acc_q;
        w_smp_d      = r_smp_q;
        w_res_d      = r_res_q;
        w_out_data_d = r_out_data_q;
        w_oe_d       = r_oe_q;
        w_val_d      = r_val_q;
        w_err_d      = r_err_q;
`ifdef TOUCH_SCAN_GATE_EN
        w_touch_d    = r_touch_q;
`endif
        case (r_state_q)
            S_IDLE: begin
                if (enable) begin
                    w_state_d = S_DRIVE;
                    w_ch_d    = '0;
                end
            end
            S_DRIVE: begin
                w_oe_d    = DRV_OE_PAT[int'(r_ch_q)*DRV_W +: DRV_W];
                w_val_d   = DRV_VAL_PAT[int'(r_ch_q)*DRV_W +: DRV_W];
                w_acc_d   = '0;
                w_cnt_d   = '0;
                w_set_d   = '0;
                w_state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_set_q == c_set_w'(SETTLE_CYC - 1)) begin
                    w_state_d = S_CONVERT;
                end else begin
                    w_set_d = r_set_q + c_set_w'(1);
                end
            end
            S_CONVERT: begin
                if (adc_valid) begin
                    w_smp_d   = adc_data;
                    w_state_d = S_ACCUM;
                end else if (r_tmo_q == c_tmo_w'(ADC_TIMEOUT - 1)) begin
                    w_err_d   = 1'b1;
                    w_ch_d    = '0;
                    w_state_d = S_DRIVE;
                end
            end
            S_ACCUM: begin
                if (!w_last_smp) begin
                    w_acc_d   = w_sum;
                    w_cnt_d   = r_cnt_q + c_cnt_w'(1);
                    w_state_d = S_CONVERT;
                end else begin
                    w_res_d = w_res_new;
                    if (!w_last_ch) begin
                        w_ch_d    = r_ch_q + c_ch_w'(1);
                        w_state_d = S_DRIVE;
                    end else if (w_frame_keep) begin
                        w_out_data_d = w_res_new;
                        w_state_d    = S_PUBLISH;
                    end else begin
`ifdef TOUCH_SCAN_GATE_EN
                        w_touch_d = 1'b0;
`endif
                        w_ch_d    = '0;
                        w_state_d = S_DRIVE;
                    end
                end
            end
            S_PUBLISH: begin
                if (out_ready) begin
`ifdef TOUCH_SCAN_GATE_EN
                    w_touch_d = 1'b1;
`endif
                    w_ch_d    = '0;
                    w_state_d = enable ? S_DRIVE : S_IDLE;
                end
            end
            default: w_state_d = S_IDLE;
        endcase

        // An offered frame is never withdrawn; every other active state aborts on enable low.
        if (!enable && (r_state_q != S_IDLE) && (r_state_q != S_PUBLISH)) begin
            w_state_d = S_IDLE;
        end
        if (w_state_d == S_IDLE) begin
            w_oe_d  = '0;
            w_val_d = '0;
        end

        w_tmo_d       = ((r_state_q == S_CONVERT) && (w_state_d == S_CONVERT))
                        ? r_tmo_q + c_tmo_w'(1) : '0;
        w_adc_req_d   = (w_state_d == S_CONVERT);
        w_out_valid_d = (w_state_d == S_PUBLISH);
    end

    always_ff @(posedge FAB_CLK) begin
        if (FAB_RESET) begin
            r_state_q     <= S_IDLE;
            r_ch_q        <= '0;
            r_set_q       <= '0;
            r_tmo_q       <= '0;
            r_cnt_q       <= '0;
            r_acc_q       <= '0;
            r_smp_q       <= '0;
            r_res_q       <= '0;
            r_out_data_q  <= '0;
            r_out_valid_q <= 1'b0;
            r_adc_req_q   <= 1'b0;
            r_oe_q        <= '0;
            r_val_q       <= '0;
            r_err_q       <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_ch_q        <= w_ch_d;
            r_set_q       <= w_set_d;
            r_tmo_q       <= w_tmo_d;
            r_cnt_q       <= w_cnt_d;
            r_acc_q       <= w_acc_d;
            r_smp_q       <= w_smp_d;
            r_res_q       <= w_res_d;
            r_out_data_q  <= w_out_data_d;
            r_out_valid_q <= w_out_valid_d;
            r_adc_req_q   <= w_adc_req_d;
            r_oe_q        <= w_oe_d;
            r_val_q       <= w_val_d;
            r_err_q       <= w_err_d;
        end
    end

`ifdef TOUCH_SCAN_GATE_EN
    always_ff @(posedge FAB_CLK) begin
        if (FAB_RESET) begin
            r_touch_q <= 1'b0;
        end else begin
            r_touch_q <= w_touch_d;
        end
    end
`endif

    assign drive_oe    = r_oe_q;
    assign drive_out   = r_val_q;
    assign adc_req     = r_adc_req_q;
    assign adc_ch      = r_ch_q;
    assign out_valid   = r_out_valid_q;
    assign out_data    = r_out_data_q;
    assign err_timeout = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_touch_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_touch_scan_sequencer
//  Desc     : Randomised self-checking bench for touch_scan_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_touch_scan_sequencer;

    localparam int SETTLE = 4;
    localparam int TMO    = 16;
`ifdef TOUCH_SCAN_GATE_EN
    localparam int C_CH0_MIN   = 200;
    localparam bit C_TOUCH_RST = 1'b0;
`else
    localparam int C_CH0_MIN   = 0;
    localparam bit C_TOUCH_RST = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [3:0]  drive_oe;
    logic [3:0]  drive_out;
    logic        adc_req;
    logic [0:0]  adc_ch;
    logic        adc_valid;
    logic [11:0] adc_data;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic        touch_active;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;

    int unsigned adc_vals[$];
    int          ch_log[$];
    logic [23:0] exp_q[$];

    always #5 clk = ~clk;

    touch_scan_sequencer #(
        .SETTLE_CYC  (SETTLE),
        .ADC_TIMEOUT (TMO)
    ) dut (
        .FAB_CLK      (clk),
        .FAB_RESET    (rst),
        .enable       (enable),
        .drive_oe     (drive_oe),
        .drive_out    (drive_out),
        .adc_req      (adc_req),
        .adc_ch       (adc_ch),
        .adc_valid    (adc_valid),
        .adc_data     (adc_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .touch_active (touch_active),
        .err_timeout  (err_timeout)
    );

    // ADC model: answers each pending request after a random delay from the value queue
    initial begin : responder
        int wait_cnt;
        int lat;
        adc_valid = 1'b0;
        adc_data  = '0;
        wait_cnt  = 0;
        lat       = 0;
        forever begin
            @(negedge clk);
            adc_valid = 1'b0;
            if (adc_req === 1'b1 && adc_vals.size() > 0) begin
                if (wait_cnt >= lat) begin
                    adc_valid = 1'b1;
                    adc_data  = 12'(adc_vals.pop_front());
                    ch_log.push_back(int'(adc_ch));
                    wait_cnt  = 0;
                    lat       = $urandom_range(0, 6);
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // Reference: each channel is the floor of the mean of its four samples
    function automatic logic [23:0] model_frame(input int unsigned s[8]);
        logic [23:0] r;
        int unsigned sum;
        r = '0;
        for (int c = 0; c < 2; c++) begin
            sum = 0;
            for (int i = 0; i < 4; i++) sum += s[c*4 + i];
            r[c*12 +: 12] = 12'(sum / 4);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int ch0_val);
        int unsigned s[8];
        for (int i = 0; i < 8; i++) begin
            if (i < 4 && ch0_val >= 0) s[i] = unsigned'(ch0_val);
            else if (i < 4)            s[i] = $urandom_range(C_CH0_MIN, 4095);
            else                       s[i] = $urandom_range(0, 4095);
            adc_vals.push_back(s[i]);
        end
        exp_q.push_back(model_frame(s));
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if ({drive_oe, drive_out, adc_req, adc_ch, out_valid, out_data, err_timeout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got oe=%h out=%h req=%b ch=%b v=%b data=%h err=%b expected all zero",
                     drive_oe, drive_out, adc_req, adc_ch, out_valid, out_data, err_timeout);
        end
        checks++;
        if (touch_active !== C_TOUCH_RST) begin
            errors++;
            $display("FAIL reset_touch: got %b expected %b", touch_active, C_TOUCH_RST);
        end
        rst = 1'b0;
        tick();
    endtask

`ifndef TOUCH_SCAN_GATE_EN
    task automatic test_spec_vector();
        int n;
        int bad;
        int unsigned v[8];
        v = '{100, 101, 102, 103, 8, 8, 8, 9};
        foreach (v[i]) adc_vals.push_back(v[i]);
        ch_log.delete();
        enable = 1'b1;
        n = 0;
        while (adc_req !== 1'b1 && n < 100) begin tick(); n++; end
        checks++;
        if (n != 2 + SETTLE) begin
            errors++;
            $display("FAIL first_req_latency: got %0d expected %0d", n, 2 + SETTLE);
        end
        checks++;
        if (drive_oe !== 4'h3 || drive_out !== 4'h1 || adc_ch !== 1'b0) begin
            errors++;
            $display("FAIL ch0_drive: got oe=%h out=%h ch=%b expected oe=3 out=1 ch=0", drive_oe, drive_out, adc_ch);
        end
        n = 0;
        while (out_valid !== 1'b1 && n < 500) begin tick(); n++; end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL spec_frame_valid: got %b expected 1", out_valid);
        end
        checks++;
        if (out_data !== {12'd8, 12'd101}) begin
            errors++;
            $display("FAIL spec_frame_data: got %h expected %h", out_data, {12'd8, 12'd101});
        end
        bad = (ch_log.size() != 8) ? 1 : 0;
        foreach (ch_log[i]) if (ch_log[i] != i / 4) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL spec_channel_order: got %0d conversions, %0d out of order, expected 8 in order", ch_log.size(), bad);
        end
        checks++;
        if (touch_active !== 1'b1) begin
            errors++;
            $display("FAIL touch_const: got %b expected 1", touch_active);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 50; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== {12'd8, 12'd101} || adc_req !== 1'b0 ||
                drive_oe !== 4'hC || drive_out !== 4'h4) begin
                errors++;
                $display("FAIL stall_cycle_%0d: got v=%b data=%h req=%b oe=%h out=%h expected v=1 data=008065 req=0 oe=c out=4",
                         i, out_valid, out_data, adc_req, drive_oe, drive_out);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL accept_drop_valid: got %b expected 0", out_valid);
        end
        tick();
        checks++;
        if (drive_oe !== 4'h3 || drive_out !== 4'h1) begin
            errors++;
            $display("FAIL restart_ch0_drive: got oe=%h out=%h expected oe=3 out=1", drive_oe, drive_out);
        end
        enable = 1'b0;
        repeat (2) tick();
        adc_vals.delete();
        ch_log.delete();
    endtask
`endif

    task automatic test_random_frames();
        int n;
        int bad;
        logic [23:0] exp;
        enable = 1'b1;
        ch_log.delete();
        push_frame(-1);
        for (int f = 0; f < 6; f++) begin
            n = 0;
            while (out_valid !== 1'b1 && n < 1000) begin tick(); n++; end
            exp = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp) begin
                errors++;
                $display("FAIL rand_frame_%0d: got v=%b data=%h expected v=1 data=%h", f, out_valid, out_data, exp);
            end
            bad = (ch_log.size() != 8) ? 1 : 0;
            foreach (ch_log[i]) if (ch_log[i] != i / 4) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL rand_order_%0d: got %0d conversions, %0d out of order, expected 8 in order", f, ch_log.size(), bad);
            end
            ch_log.delete();
            if (f < 5) push_frame(-1);
            else       enable = 1'b0;
            repeat ($urandom_range(0, 5)) tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp) begin
                errors++;
                $display("FAIL rand_hold_%0d: got v=%b data=%h expected v=1 data=%h", f, out_valid, out_data, exp);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (drive_oe !== 4'h0 || adc_req !== 1'b0 || out_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_after_accept: got %0d active cycles expected 0", bad);
        end
    endtask

`ifdef TOUCH_SCAN_GATE_EN
    task automatic test_touch_gate();
        int n;
        logic [23:0] exp;
        enable = 1'b1;
        push_frame(150);
        push_frame(300);
        void'(exp_q.pop_front());
        exp = exp_q.pop_front();
        n = 0;
        while (out_valid !== 1'b1 && n < 2000) begin tick(); n++; end
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp) begin
            errors++;
            $display("FAIL gate_first_published: got v=%b data=%h expected v=1 data=%h", out_valid, out_data, exp);
        end
        checks++;
        if (touch_active !== 1'b0) begin
            errors++;
            $display("FAIL gate_touch_after_drop: got %b expected 0", touch_active);
        end
        enable = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        checks++;
        if (touch_active !== 1'b1) begin
            errors++;
            $display("FAIL gate_touch_after_accept: got %b expected 1", touch_active);
        end
        adc_vals.delete();
        ch_log.delete();
    endtask
`endif

    task automatic test_timeout();
        int n;
        int cnt;
        int bad;
        logic [23:0] exp;
        ch_log.delete();
        enable = 1'b1;
        n = 0;
        while (adc_req !== 1'b1 && n < 100) begin tick(); n++; end
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL tmo_err_before: got %b expected 0", err_timeout);
        end
        cnt = 0;
        bad = 0;
        while (adc_req === 1'b1 && cnt < 100) begin
            if (out_valid !== 1'b0) bad++;
            tick();
            cnt++;
        end
        checks++;
        if (cnt != TMO || bad != 0) begin
            errors++;
            $display("FAIL tmo_req_cycles: got %0d cycles (%0d with out_valid) expected %0d", cnt, bad, TMO);
        end
        checks++;
        if (err_timeout !== 1'b1) begin
            errors++;
            $display("FAIL tmo_err_set: got %b expected 1", err_timeout);
        end
        push_frame(-1);
        exp = exp_q.pop_front();
        n = 0;
        while (out_valid !== 1'b1 && n < 1000) begin tick(); n++; end
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp || ch_log.size() != 8 || ch_log[0] != 0) begin
            errors++;
            $display("FAIL tmo_recovery: got v=%b data=%h conv=%0d expected v=1 data=%h conv=8 from ch0",
                     out_valid, out_data, ch_log.size(), exp);
        end
        enable = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        ch_log.delete();
    endtask

    task automatic test_enable_drop();
        int n;
        int bad;
        enable = 1'b1;
        push_frame(-1);
        void'(exp_q.pop_front());
        n = 0;
        while (drive_oe !== 4'hC && n < 500) begin tick(); n++; end
        enable = 1'b0;
        tick();
        checks++;
        if (drive_oe !== 4'h0 || adc_req !== 1'b0) begin
            errors++;
            $display("FAIL drop_idle: got oe=%h req=%b expected oe=0 req=0", drive_oe, adc_req);
        end
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid !== 1'b0 || adc_req !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL drop_no_frame: got %0d active cycles expected 0", bad);
        end
        checks++;
        if (err_timeout !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b expected 1", err_timeout);
        end
        adc_vals.delete();
        ch_log.delete();
    endtask

    task automatic test_reset_mid_convert();
        int n;
        enable = 1'b1;
        n = 0;
        while (adc_req !== 1'b1 && n < 100) begin tick(); n++; end
        repeat (3) tick();
        rst = 1'b1;
        enable = 1'b0;
        tick();
        checks++;
        if (adc_req !== 1'b0 || drive_oe !== 4'h0 || out_valid !== 1'b0 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_convert: got req=%b oe=%h v=%b err=%b expected all 0",
                     adc_req, drive_oe, out_valid, err_timeout);
        end
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        out_ready = 1'b0;
        test_reset();
`ifndef TOUCH_SCAN_GATE_EN
        test_spec_vector();
        test_backpressure();
`endif
        test_random_frames();
`ifdef TOUCH_SCAN_GATE_EN
        test_touch_gate();
`endif
        test_timeout();
        test_enable_drop();
        test_reset_mid_convert();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
